// File: rtl/aimbot_video_pkg.sv
// Shared types for the video tracking path: FSM states, pixel struct, channel distance helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a (the video stream is free-running and cannot be stalled).
package aimbot_video_pkg;

    typedef enum logic [1:0] {
        WAIT_VS,
        SCAN,
        COMMIT
    } bbox_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Distance between two channel values, kept at 9 bits so that a tolerance
    // of 255 still compares cleanly against a difference of 255.
    function automatic logic [8:0] chan_dist(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] wa;
        logic [8:0] wb;
        wa = {1'b0, a};
        wb = {1'b0, b};
        return (wa >= wb) ? (wa - wb) : (wb - wa);
    endfunction

endpackage

// File: rtl/color_match.sv
// Combinational test of one pixel against the key colour within a per-channel tolerance.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; evaluated on every pixel presented.
module color_match
    import aimbot_video_pkg::*;
(
    input  rgb_t       pix,
    input  rgb_t       key,
    input  logic [7:0] tol,
    output logic       hit
);

    // All three channels must fall inside the tolerance window.
    always_comb begin
        hit = (chan_dist(pix.r, key.r) <= {1'b0, tol}) &&
              (chan_dist(pix.g, key.g) <= {1'b0, tol}) &&
              (chan_dist(pix.b, key.b) <= {1'b0, tol});
    end

endmodule

// File: rtl/color_bbox.sv
// Per-frame colour tracker: delays video one clock with x/y tags, publishes the matched-pixel bounding box at each vsync.
// Latency: video 1 clock; box and frame_done visible 2 clocks after the vsync rising edge is driven.
// Backpressure: none; the stream is free-running and a pixel during the commit cycle is dropped.
module color_bbox
    import aimbot_video_pkg::*;
#(
    parameter int H_ACT      = 1280,
    parameter int V_ACT      = 720,
    parameter int MIN_PIXELS = 16,
    localparam int XW        = $clog2(H_ACT),
    localparam int YW        = $clog2(V_ACT)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [23:0]   key_color,
    input  logic [7:0]    tol,
    input  logic          i_hsync,
    input  logic          i_vsync,
    input  logic          i_de,
    input  logic [7:0]    i_r,
    input  logic [7:0]    i_g,
    input  logic [7:0]    i_b,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_de,
    output logic [7:0]    o_r,
    output logic [7:0]    o_g,
    output logic [7:0]    o_b,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic [XW-1:0] start_x,
    output logic [XW-1:0] end_x,
    output logic [YW-1:0] start_y,
    output logic [YW-1:0] end_y,
    output logic          box_valid,
    output logic          frame_done
);

    localparam int            CW      = $clog2(H_ACT * V_ACT + 1);
    localparam logic [XW-1:0] X_MAX   = XW'(H_ACT - 1);
    localparam logic [YW-1:0] Y_MAX   = YW'(V_ACT - 1);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] MIN_CNT = CW'(MIN_PIXELS);

    bbox_state_t   state;
    bbox_state_t   next_state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [XW-1:0] min_x;
    logic [XW-1:0] max_x;
    logic [YW-1:0] min_y;
    logic [YW-1:0] max_y;
    logic [CW-1:0] cnt;
    rgb_t          key_sh;
    logic [7:0]    tol_sh;
    rgb_t          pix_in;
    logic          hit;
    logic          vs_rise;
    logic          de_fall;
    logic          acc_en;
    logic          acc_clr;
    logic          commit;

    // The delayed o_vsync/o_de registers double as the previous-cycle samples for edge detection.
    assign vs_rise = i_vsync & ~o_vsync;
    assign de_fall = ~i_de & o_de;
    assign pix_in  = '{r: i_r, g: i_g, b: i_b};

    color_match u_match (
        .pix (pix_in),
        .key (key_sh),
        .tol (tol_sh),
        .hit (hit)
    );

    // One-clock video delay, tagged with the coordinates of the pixel being forwarded.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            o_hsync <= 1'b0;
            o_vsync <= 1'b0;
            o_de    <= 1'b0;
            o_r     <= '0;
            o_g     <= '0;
            o_b     <= '0;
            o_x     <= '0;
            o_y     <= '0;
        end else begin
            o_hsync <= i_hsync;
            o_vsync <= i_vsync;
            o_de    <= i_de;
            o_r     <= i_r;
            o_g     <= i_g;
            o_b     <= i_b;
            o_x     <= x;
            o_y     <= y;
        end
    end

    // Column/line counters; both saturate so over-long lines or frames reuse the last index.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            x <= '0;
            y <= '0;
        end else begin
            if (i_de) begin
                if (x != X_MAX) x <= x + 1'b1;
            end else if (de_fall) begin
                x <= '0;
            end
            if (vs_rise) begin
                y <= '0;
            end else if (de_fall && (y != Y_MAX)) begin
                y <= y + 1'b1;
            end
        end
    end

    // Key and tolerance only change at frame boundaries so a frame is matched consistently.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            key_sh <= '0;
            tol_sh <= '0;
        end else if (vs_rise) begin
            key_sh <= rgb_t'(key_color);
            tol_sh <= tol;
        end
    end

    // Frame FSM state register.
    always_ff @(posedge clk) begin
        if (!rstn) state <= WAIT_VS;
        else       state <= next_state;
    end

    // Next state plus accumulate/clear/commit strobes.
    always_comb begin
        next_state = state;
        acc_en     = 1'b0;
        acc_clr    = 1'b0;
        commit     = 1'b0;
        case (state)
            WAIT_VS: begin
                if (vs_rise) begin
                    acc_clr    = 1'b1;
                    next_state = SCAN;
                end
            end
            SCAN: begin
                // A pixel coinciding with the vsync edge still belongs to the outgoing frame.
                acc_en = i_de & hit;
                if (vs_rise) next_state = COMMIT;
            end
            COMMIT: begin
                commit     = 1'b1;
                acc_clr    = 1'b1;
                next_state = SCAN;
            end
            default: next_state = WAIT_VS;
        endcase
    end

    // Bounding-box and matched-pixel accumulators for the frame in progress.
    always_ff @(posedge clk) begin
        if (!rstn || acc_clr) begin
            min_x <= '1;
            min_y <= '1;
            max_x <= '0;
            max_y <= '0;
            cnt   <= '0;
        end else if (acc_en) begin
            if (x < min_x) min_x <= x;
            if (y < min_y) min_y <= y;
            if (x > max_x) max_x <= x;
            if (y > max_y) max_y <= y;
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        end
    end

    // Published box: updated once per frame and held until the next commit.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            start_x    <= '0;
            start_y    <= '0;
            end_x      <= '0;
            end_y      <= '0;
            box_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= commit;
            if (commit) begin
                if (cnt >= MIN_CNT) begin
                    start_x   <= min_x;
                    start_y   <= min_y;
                    end_x     <= max_x;
                    end_y     <= max_y;
                    box_valid <= 1'b1;
                end else begin
                    start_x   <= '0;
                    start_y   <= '0;
                    end_x     <= '0;
                    end_y     <= '0;
                    box_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_color_bbox.sv
// Directed bench for color_bbox on a 16x8 raster with hand-computed boxes.
// Latency: checks video at 1 clock and box/frame_done at the second vsync cycle.
// Backpressure: none; stimulus is a free-running raster.
module tb_color_bbox;

    localparam int H  = 16;
    localparam int V  = 8;
    localparam int MP = 4;
    localparam int XW = $clog2(H);
    localparam int YW = $clog2(V);

    logic          clk;
    logic          rstn;
    logic [23:0]   key_color;
    logic [7:0]    tol;
    logic          i_hsync, i_vsync, i_de;
    logic [7:0]    i_r, i_g, i_b;
    logic          o_hsync, o_vsync, o_de;
    logic [7:0]    o_r, o_g, o_b;
    logic [XW-1:0] o_x;
    logic [YW-1:0] o_y;
    logic [XW-1:0] start_x, end_x;
    logic [YW-1:0] start_y, end_y;
    logic          box_valid, frame_done;

    color_bbox #(.H_ACT(H), .V_ACT(V), .MIN_PIXELS(MP)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .key_color  (key_color),
        .tol        (tol),
        .i_hsync    (i_hsync),
        .i_vsync    (i_vsync),
        .i_de       (i_de),
        .i_r        (i_r),
        .i_g        (i_g),
        .i_b        (i_b),
        .o_hsync    (o_hsync),
        .o_vsync    (o_vsync),
        .o_de       (o_de),
        .o_r        (o_r),
        .o_g        (o_g),
        .o_b        (o_b),
        .o_x        (o_x),
        .o_y        (o_y),
        .start_x    (start_x),
        .end_x      (end_x),
        .start_y    (start_y),
        .end_y      (end_y),
        .box_valid  (box_valid),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Scene description: up to two solid rectangles, or the long-line pattern.
    logic        a_on, b_on, mode6, chk_video;
    int          a_x0, a_x1, a_y0, a_y1;
    int          b_x0, b_x1, b_y0, b_y1;
    logic [23:0] a_col, b_col, key_next;
    int          chg_line;
    logic [3:0]  fd_at;
    logic [3:0]  bv_at;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] pix(input int c, input int ln);
        if (mode6) return (c == 19 && ln >= 3 && ln <= 6) ? 24'hFF0000 : 24'h000000;
        if (a_on && c >= a_x0 && c <= a_x1 && ln >= a_y0 && ln <= a_y1) return a_col;
        if (b_on && c >= b_x0 && c <= b_x1 && ln >= b_y0 && ln <= b_y1) return b_col;
        return 24'h000000;
    endfunction

    task automatic cyc(input logic hs, input logic vs, input logic de, input logic [23:0] c);
        i_hsync = hs;
        i_vsync = vs;
        i_de    = de;
        {i_r, i_g, i_b} = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send_lines(input int first, input int last, input int len);
        logic [23:0] p;
        for (int ln = first; ln <= last; ln++) begin
            if (ln == chg_line) key_color = key_next;
            for (int c = 0; c < len; c++) begin
                p = pix(c, ln);
                cyc(1'b0, 1'b0, 1'b1, p);
                if (chk_video && ln <= 2) begin
                    chk("vid_de", 32'(o_de), 32'd1);
                    chk("vid_x", 32'(o_x), 32'(c));
                    chk("vid_y", 32'(o_y), 32'(ln));
                    chk("vid_rgb", {8'h0, o_r, o_g, o_b}, {8'h0, p});
                end
                if (len > H && c == len - 1) chk("x_sat", 32'(o_x), 32'(H - 1));
            end
            for (int k = 0; k < 4; k++) begin
                cyc(k == 1 || k == 2, 1'b0, 1'b0, 24'h0);
                if (chk_video && ln == 0 && k == 0) chk("vid_de_low", 32'(o_de), 32'd0);
            end
        end
    endtask

    task automatic vsync_pulse();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, i < 2, 1'b0, 24'h0);
            fd_at[i] = frame_done;
            bv_at[i] = box_valid;
        end
    endtask

    task automatic check_box(input string tag, input logic v, input int sx, input int sy,
                             input int ex, input int ey);
        chk({tag, "_fd_pos"}, 32'(fd_at[1]), 32'd1);
        chk({tag, "_fd_once"}, 32'($countones(fd_at)), 32'd1);
        chk({tag, "_valid"}, 32'(box_valid), 32'(v));
        chk({tag, "_sx"}, 32'(start_x), 32'(sx));
        chk({tag, "_sy"}, 32'(start_y), 32'(sy));
        chk({tag, "_ex"}, 32'(end_x), 32'(ex));
        chk({tag, "_ey"}, 32'(end_y), 32'(ey));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_valid"}, 32'(box_valid), 32'd0);
        chk({tag, "_fd"}, 32'(frame_done), 32'd0);
        chk({tag, "_box"}, 32'({start_x, start_y, end_x, end_y}), 32'd0);
        chk({tag, "_video"}, 32'({o_hsync, o_vsync, o_de, o_x, o_y}), 32'd0);
        chk({tag, "_rgb"}, {8'h0, o_r, o_g, o_b}, 32'd0);
    endtask

    initial begin
        rstn = 1'b0; key_color = 24'hFF0000; tol = 8'd16;
        i_hsync = 0; i_vsync = 0; i_de = 0; i_r = 0; i_g = 0; i_b = 0;
        a_on = 0; b_on = 0; mode6 = 0; chk_video = 0; chg_line = -1;
        a_x0 = 0; a_x1 = 0; a_y0 = 0; a_y1 = 0; b_x0 = 0; b_x1 = 0; b_y0 = 0; b_y1 = 0;
        a_col = 0; b_col = 0; key_next = 0; fd_at = 0; bv_at = 0;

        repeat (3) cyc(1'b0, 1'b0, 1'b0, 24'h0);
        check_reset("reset");
        rstn = 1'b1;
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 24'h0);
        vsync_pulse();
        chk("first_vs_no_fd", 32'($countones(fd_at)), 32'd0);

        // 1: black frame, no box; video delayed with coordinates
        chk_video = 1;
        send_lines(0, V - 1, H);
        chk_video = 0;
        vsync_pulse();
        check_box("t1", 1'b0, 0, 0, 0, 0);

        // 2: 4x3 near-red rectangle
        a_on = 1; a_x0 = 5; a_x1 = 8; a_y0 = 2; a_y1 = 4; a_col = 24'hF00808;
        send_lines(0, V - 1, H);
        vsync_pulse();
        chk("t2_not_early", 32'(bv_at[0]), 32'd0);
        check_box("t2", 1'b1, 5, 2, 8, 4);

        // 3a: only three matching pixels
        a_x1 = 7; a_y1 = 2; a_col = 24'hFF0000;
        send_lines(0, V - 1, H);
        tol = 8'd0;
        vsync_pulse();
        check_box("t3a", 1'b0, 0, 0, 0, 0);

        // 3b: exact match required, EF0000 rejected
        a_x1 = 8; a_y1 = 4; a_col = 24'hEF0000;
        send_lines(0, V - 1, H);
        tol = 8'd16;
        vsync_pulse();
        check_box("t3b", 1'b0, 0, 0, 0, 0);

        // 4: key switched to green mid-frame takes effect next frame
        a_col = 24'hF00808;
        b_on = 1; b_x0 = 10; b_x1 = 12; b_y0 = 6; b_y1 = 7; b_col = 24'h00FF00;
        key_next = 24'h00FF00; chg_line = 5;
        send_lines(0, V - 1, H);
        chg_line = -1;
        vsync_pulse();
        check_box("t4a", 1'b1, 5, 2, 8, 4);
        send_lines(0, V - 1, H);
        vsync_pulse();
        check_box("t4b", 1'b1, 10, 6, 12, 7);

        // 5: reset mid-frame discards the partial frame
        key_color = 24'hFF0000; b_on = 0;
        send_lines(0, 3, H);
        rstn = 1'b0;
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 24'h0);
        check_reset("t5_rst");
        rstn = 1'b1;
        send_lines(4, V - 1, H);
        vsync_pulse();
        chk("t5_no_fd", 32'($countones(fd_at)), 32'd0);
        chk("t5_hold_invalid", 32'(box_valid), 32'd0);
        send_lines(0, V - 1, H);
        vsync_pulse();
        check_box("t5", 1'b1, 5, 2, 8, 4);

        // 6: 20-cycle lines, match on the last pixel only
        a_on = 0; mode6 = 1;
        send_lines(0, V - 1, 20);
        vsync_pulse();
        check_box("t6", 1'b1, 15, 3, 15, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/color_bbox.md
# color_bbox

Per-frame target tracker between the video input and `draw_window`. Generates the active-pixel coordinates (`o_x`, `o_y`) and a one-cycle-delayed copy of the video stream for `draw_window`. Matches each active pixel against a programmable key colour with tolerance and accumulates the bounding box of matching pixels. At every frame boundary it publishes one `start/end` box in the `draw_window` format, where all-zero coordinates mean "no box".

## Interface
Parameters:
- `H_ACT`, 12'd1280: active pixels per line; `XW = $clog2(H_ACT)`.
- `V_ACT`, 12'd720: active lines per frame; `YW = $clog2(V_ACT)`.
- `MIN_PIXELS`, 16: minimum matched-pixel count for a valid box.

Ports:
- `clk` in 1: pixel clock.
- `rstn` in 1: synchronous, active-low reset.
- `key_color` in 24: target colour, packed as {r,g,b}.
- `tol` in 8: per-channel tolerance.
- `i_hsync`, `i_vsync`, `i_de` in 1 each: active-high sync and data enable.
- `i_r`, `i_g`, `i_b` in 8 each: pixel data.
- `o_hsync`, `o_vsync`, `o_de` out 1 each: delayed sync and data enable.
- `o_r`, `o_g`, `o_b` out 8 each: delayed pixel data.
- `o_x` out XW: column of the pixel on the `o_*` outputs.
- `o_y` out YW: line of the pixel on the `o_*` outputs.
- `start_x`, `end_x` out XW: box columns.
- `start_y`, `end_y` out YW: box lines.
- `box_valid` out 1: the published box is valid.
- `frame_done` out 1: one-cycle pulse when the box outputs update.

## Operation
- Coordinates:
  - `x` increments on each `i_de` cycle and clears on the `i_de` falling edge.
  - `y` increments on each `i_de` falling edge and clears on the `i_vsync` rising edge.
  - Both saturate at `H_ACT-1` and `V_ACT-1`.
- Match: pixel matches when `|i_c - key_c| <= tol` for all three channels, using 9-bit unsigned differences.
  - `tol=0` means an exact match.
  - `tol=255` matches every pixel.
- Key/tol shadowing: `key_color` and `tol` are copied into shadow registers on each `i_vsync` rising edge. Mid-frame changes take effect the next frame.
- Accumulators: `min_x`, `min_y` (init all-ones), `max_x`, `max_y` (init 0), and `cnt`.
  - `cnt` is `$clog2(H_ACT*V_ACT+1)` bits wide and saturating.
  - On a matching `i_de` pixel: `min` and `max` update, `cnt++`.
- FSM:
  - WAIT_VS (reset state): pixels ignored. On vsync rising edge, clear accumulators and latch the shadows, then go to SCAN.
  - SCAN: accumulate. On vsync rising edge, go to COMMIT.
  - COMMIT (1 cycle), then back to SCAN with accumulators cleared and shadows latched:
    - If `cnt >= MIN_PIXELS`: register `start_x=min_x`, `start_y=min_y`, `end_x=max_x`, `end_y=max_y`, `box_valid=1`.
    - Else: all four coordinates 0 and `box_valid=0`.
    - `frame_done` is pulsed in both cases.
- A pixel with `i_de` high during the COMMIT cycle is dropped. This is legal only for illegal timing.
- Box outputs hold between commits.

## Timing
- Video path: `o_hsync/o_vsync/o_de/o_r/o_g/o_b/o_x/o_y` are registered and lag the inputs by exactly 1 clock. `o_x/o_y` are aligned with `o_r/g/b`.
- Box update: let N be the first edge sampling `i_vsync=1` after SCAN. COMMIT is at cycle N+1, and the box outputs plus `frame_done` are visible after edge N+1. The first box follows the first full frame after reset.
- `frame_done` is high for exactly 1 cycle per frame.
- Reset: every output is 0 and the FSM goes to WAIT_VS. Reset mid-frame discards the partial frame, and no `frame_done` is issued for it.
- Simultaneous `i_de` and vsync edge: the pixel is counted in the outgoing frame.
- `i_de` longer than `H_ACT`: extra pixels reuse `x=H_ACT-1`.

## Structure
- Package `aimbot_video_pkg`:
  - `bbox_state_t` enum {WAIT_VS, SCAN, COMMIT}.
  - `rgb_t` packed struct {r,g,b}.
- Sub-module `color_match`: combinational compare of one pixel against key/tol, returns 1 bit.

## Test plan
Bench overrides `H_ACT=16`, `V_ACT=8`, `MIN_PIXELS=4`, with `key=FF0000` and `tol=16` unless noted.
1. All-black frame, then vsync -> `frame_done` pulses once; `box_valid=0`; all coordinates 0. `o_*` equal the inputs delayed 1 clock, with `o_x` 0..15.
2. F0_08_08 rectangle at x 5..8, y 2..4 (12 px) -> `start=(5,2)`, `end=(8,4)`, `box_valid=1`, appearing 2 clocks after `i_vsync` rises.
3. Only 3 matching pixels -> `box_valid=0`, all coordinates 0. Then `tol=0` with pixel EF0000 -> no match.
4. `key_color` changed to 00FF00 mid-frame -> the current frame is still matched on red; the next frame is matched on green.
5. `rstn` low for 2 cycles mid-frame -> all outputs 0; no `frame_done` at the next vsync. The following full frame reports the correct box.
6. `i_de` held 20 cycles with the matching pixel at the last cycle -> `end_x=15`; `o_x` saturates at 15.
